pipe_hazard_ctrl: RTL and testbench

Hazard and stall controller for the five-stage CPU pipeline. It watches the decode (ID) and execute (EX) stages and drives the PC, IF/ID and ID/EX registers. It sequences three events: load-use stalls, taken-branch/jump flushes, and multi-cycle multiply/divide occupancy of HI/LO. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/cpu_pipe_pkg.sv | 15 +
 rtl/pipe_hazard_ctrl_md_busy_timer.sv | 32 +++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline types and constants.
// Register-address width, the zero register and hazard cause codes.
package cpu_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    HZ_NONE,
    HZ_FLUSH,
    HZ_LOADUSE,
    HZ_MD
  } hz_cause_e;

endpackage

// File: rtl/pipe_hazard_ctrl_md_busy_timer.sv
// Mult/div occupancy timer: counts down from MD_LAT after an issue.
// HI/LO are valid again once the count reaches zero.
module md_busy_timer #(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic md_busy
);

  logic [4:0] md_cnt_d;
  logic [4:0] md_cnt_q;

  always_comb begin
    md_cnt_d = md_cnt_q;
    if (load)
      md_cnt_d = 5'(MD_LAT);
    else if (md_cnt_q != 5'd0)
      md_cnt_d = md_cnt_q - 5'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      md_cnt_q <= '0;
    else
      md_cnt_q <= md_cnt_d;
  end

  assign md_busy = (md_cnt_q != 5'd0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: load-use stalls, branch flushes,
// mult/div HI/LO occupancy, plus saturating event counters.
module pipe_hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_memr,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic                  id_md_start,
  input  logic                  id_md_read,
  output logic                  pc_wr,
  output logic                  if_id_wr,
  output logic                  if_id_flush,
  output logic                  id_ex_stall,
  output logic                  md_issue,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);

  logic      lu_haz;
  logic      md_haz;
  hz_cause_e cause;

  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  md_busy_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (md_issue),
    .md_busy (md_busy)
  );

  assign lu_haz = ex_memr && (ex_rd != ZERO_REG) &&
                  ((id_uses_rs && ex_rd == id_rs) ||
                   (id_uses_rt && ex_rd == id_rt));
  assign md_haz = md_busy && (id_md_read || id_md_start);

  always_comb begin
    cause = HZ_NONE;
    priority case (1'b1)
      ex_branch_taken: cause = HZ_FLUSH;
      lu_haz:          cause = HZ_LOADUSE;
      md_haz:          cause = HZ_MD;
      default:         cause = HZ_NONE;
    endcase
  end

  // Reset values hold the front end frozen with a bubble into EX.
  always_comb begin
    pc_wr       = 1'b0;
    if_id_wr    = 1'b0;
    if_id_flush = 1'b1;
    id_ex_stall = 1'b1;
    md_issue    = 1'b0;
    if (rst_n) begin
      unique case (cause)
        HZ_FLUSH: begin
          pc_wr       = 1'b1;
          if_id_wr    = 1'b1;
          if_id_flush = 1'b1;
          id_ex_stall = 1'b1;
        end
        HZ_LOADUSE, HZ_MD: begin
          pc_wr       = 1'b0;
          if_id_wr    = 1'b0;
          if_id_flush = 1'b0;
          id_ex_stall = 1'b1;
        end
        default: begin
          pc_wr       = 1'b1;
          if_id_wr    = 1'b1;
          if_id_flush = 1'b0;
          id_ex_stall = 1'b0;
          md_issue    = id_md_start;
        end
      endcase
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((cause == HZ_LOADUSE || cause == HZ_MD) && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (cause == HZ_FLUSH && !(&flush_cnt_q))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed vector table, saturation run,
// then random stimulus against a timestamp-based reference model.
module tb_pipe_hazard_ctrl;

  localparam int MD_LAT = 4;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       memr;
    logic [4:0] rd;
    logic       br;
    logic       mds;
    logic       mdr;
  } in_t;

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        fl;
    logic        st;
    logic        iss;
    logic        busy;
    logic [15:0] sc;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rs, id_uses_rt, ex_memr;
  logic       ex_branch_taken, id_md_start, id_md_read;

  logic        pc_wr, if_id_wr, if_id_flush, id_ex_stall;
  logic        md_issue, md_busy;
  logic [15:0] stall_cnt, flush_cnt;

  logic       pc_wr_s, if_id_wr_s, if_id_flush_s, id_ex_stall_s;
  logic       md_issue_s, md_busy_s;
  logic [3:0] stall_cnt_s, flush_cnt_s;

  int n_vec = 0;
  int n_err = 0;

  int cyc = 0;
  int last_issue = -1000;
  int m_sc = 0;
  int m_fc = 0;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_memr         (ex_memr),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .id_md_start     (id_md_start),
    .id_md_read      (id_md_read),
    .pc_wr           (pc_wr),
    .if_id_wr        (if_id_wr),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .md_issue        (md_issue),
    .md_busy         (md_busy),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(4)) dut_s (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .ex_memr         (ex_memr),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .id_md_start     (id_md_start),
    .id_md_read      (id_md_read),
    .pc_wr           (pc_wr_s),
    .if_id_wr        (if_id_wr_s),
    .if_id_flush     (if_id_flush_s),
    .id_ex_stall     (id_ex_stall_s),
    .md_issue        (md_issue_s),
    .md_busy         (md_busy_s),
    .stall_cnt       (stall_cnt_s),
    .flush_cnt       (flush_cnt_s)
  );

  function automatic in_t vin(
    input logic r, input int rs, input int rt,
    input logic urs, input logic urt, input logic memr,
    input int rd, input logic br, input logic mds, input logic mdr);
    in_t v;
    v.rst_n = r;
    v.rs = 5'(rs);
    v.rt = 5'(rt);
    v.urs = urs;
    v.urt = urt;
    v.memr = memr;
    v.rd = 5'(rd);
    v.br = br;
    v.mds = mds;
    v.mdr = mdr;
    return v;
  endfunction

  function automatic out_t vout(
    input logic pc, input logic ifid, input logic fl,
    input logic st, input logic iss, input logic busy,
    input int sc, input int fc);
    out_t o;
    o.pc = pc;
    o.ifid = ifid;
    o.fl = fl;
    o.st = st;
    o.iss = iss;
    o.busy = busy;
    o.sc = 16'(sc);
    o.fc = 16'(fc);
    return o;
  endfunction

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic bit m_busy();
    return (cyc > last_issue) && (cyc <= last_issue + MD_LAT);
  endfunction

  function automatic bit m_lu(input in_t v);
    return v.memr && v.rd != 0 &&
           ((v.urs && v.rd == v.rs) || (v.urt && v.rd == v.rt));
  endfunction

  function automatic out_t model_out(input in_t v, input int w);
    out_t o;
    bit   stall;
    stall = m_lu(v) || (m_busy() && (v.mdr || v.mds));
    o.busy = m_busy();
    o.sc = 16'(sat(m_sc, w));
    o.fc = 16'(sat(m_fc, w));
    o.iss = 1'b0;
    if (!v.rst_n)
      {o.pc, o.ifid, o.fl, o.st} = 4'b0011;
    else if (v.br)
      {o.pc, o.ifid, o.fl, o.st} = 4'b1111;
    else if (stall)
      {o.pc, o.ifid, o.fl, o.st} = 4'b0001;
    else begin
      {o.pc, o.ifid, o.fl, o.st} = 4'b1100;
      o.iss = v.mds;
    end
    return o;
  endfunction

  function automatic void model_commit(input in_t v);
    bit stall;
    stall = m_lu(v) || (m_busy() && (v.mdr || v.mds));
    if (!v.rst_n) begin
      m_sc = 0;
      m_fc = 0;
      last_issue = -1000;
    end else if (v.br)
      m_fc++;
    else if (stall)
      m_sc++;
    else if (v.mds)
      last_issue = cyc;
    cyc++;
  endfunction

  task automatic check(input string nm, input out_t got, input out_t exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // mode 0: no check, 1: table expectation, 2: reference model
  task automatic apply(input in_t v, input int mode, input out_t exp_t,
                       input string nm);
    out_t got, got_s;
    @(posedge clk);
    #1;
    rst_n = v.rst_n;
    id_rs = v.rs;
    id_rt = v.rt;
    id_uses_rs = v.urs;
    id_uses_rt = v.urt;
    ex_memr = v.memr;
    ex_rd = v.rd;
    ex_branch_taken = v.br;
    id_md_start = v.mds;
    id_md_read = v.mdr;
    @(negedge clk);
    got = {pc_wr, if_id_wr, if_id_flush, id_ex_stall,
           md_issue, md_busy, stall_cnt, flush_cnt};
    got_s = {pc_wr_s, if_id_wr_s, if_id_flush_s, id_ex_stall_s,
             md_issue_s, md_busy_s, 12'd0, stall_cnt_s,
             12'd0, flush_cnt_s};
    if (mode == 1)
      check(nm, got, exp_t);
    else if (mode == 2) begin
      check(nm, got, model_out(v, 16));
      check({nm, "_w4"}, got_s, model_out(v, 4));
    end
    model_commit(v);
  endtask

  initial begin
    in_t  v;
    out_t z;
    out_t h;
    z = '0;
    rst_n = 1'b0;
    {id_rs, id_rt, ex_rd} = '0;
    {id_uses_rs, id_uses_rt, ex_memr} = '0;
    {ex_branch_taken, id_md_start, id_md_read} = '0;

    tbl.push_back('{vin(0,0,0,0,0,0,0,0,0,0), vout(0,0,1,1,0,0,0,0)});
    tbl.push_back('{vin(1,2,0,1,0,1,2,0,0,0), vout(0,0,0,1,0,0,0,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,0), vout(1,1,0,0,0,0,1,0)});
    tbl.push_back('{vin(1,0,0,1,1,1,0,0,0,0), vout(1,1,0,0,0,0,1,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(1,1,0,0,1,0,1,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,1), vout(0,0,0,1,0,1,1,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,1), vout(0,0,0,1,0,1,2,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,1), vout(0,0,0,1,0,1,3,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,1), vout(0,0,0,1,0,1,4,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,1), vout(1,1,0,0,0,0,5,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(1,1,0,0,1,0,5,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,1,1,1), vout(1,1,1,1,0,1,5,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,0), vout(1,1,0,0,0,1,5,1)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(0,0,0,1,0,1,5,1)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(0,0,0,1,0,1,6,1)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(1,1,0,0,1,0,7,1)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,0), vout(1,1,0,0,0,1,7,1)});
    tbl.push_back('{vin(0,0,0,0,0,0,0,0,0,0), vout(0,0,1,1,0,1,7,1)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,0), vout(1,1,0,0,0,0,0,0)});
    tbl.push_back('{vin(1,7,5,0,1,1,5,0,0,0), vout(0,0,0,1,0,0,0,0)});
    tbl.push_back('{vin(1,7,5,0,0,1,5,0,0,0), vout(1,1,0,0,0,0,1,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,1,0), vout(1,1,0,0,1,0,1,0)});
    tbl.push_back('{vin(1,3,0,1,0,1,3,0,0,1), vout(0,0,0,1,0,1,1,0)});
    tbl.push_back('{vin(1,0,0,0,0,0,0,0,0,0), vout(1,1,0,0,0,1,2,0)});

    apply(vin(0,0,0,0,0,0,0,0,0,0), 0, z, "preamble");
    foreach (tbl[k])
      apply(tbl[k].i, 1, tbl[k].o, $sformatf("tbl%0d", k));

    apply(vin(0,0,0,0,0,0,0,0,0,0), 2, z, "sat_rst");
    for (int k = 0; k < 20; k++)
      apply(vin(1,2,0,1,0,1,2,0,0,0), 2, z, "sat_hold");
    apply(vin(1,0,0,0,0,0,0,0,0,0), 2, z, "sat_end");
    h = '0;
    h.sc = {12'd0, stall_cnt_s};
    check("sat_w4_cnt", h, vout(0,0,0,0,0,0,15,0));
    h.sc = stall_cnt;
    check("sat_w16_cnt", h, vout(0,0,0,0,0,0,20,0));

    for (int k = 0; k < 3000; k++) begin
      v.rst_n = ($urandom_range(99) >= 2);
      v.rs = 5'($urandom_range(3));
      v.rt = 5'($urandom_range(3));
      v.urs = 1'($urandom);
      v.urt = 1'($urandom);
      v.memr = ($urandom_range(99) < 30);
      v.rd = 5'($urandom_range(3));
      v.br = ($urandom_range(99) < 10);
      v.mds = ($urandom_range(99) < 15);
      v.mdr = ($urandom_range(99) < 15);
      apply(v, 2, z, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
